// File: rtl/mem_bus_pkg.sv
// Shared memory-bus definitions: SIZE encodings, controller FSM states and
// small decode helpers used by the data and (future) instruction bus controllers.
package mem_bus_pkg;

  typedef logic [1:0] size_t;

  localparam size_t SZ_WORD = 2'b00;
  localparam size_t SZ_HALF = 2'b01;
  localparam size_t SZ_BYTE = 2'b10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUS  = 1'b1
  } state_e;

  // Encoding 2'b11 is folded onto byte so downstream logic sees three sizes only.
  function automatic size_t norm_size(input size_t sz);
    return (sz == 2'b11) ? SZ_BYTE : sz;
  endfunction

  function automatic logic misaligned(input size_t sz, input logic [1:0] lsb);
    return ((sz == SZ_WORD) && (lsb != 2'b00)) || ((sz == SZ_HALF) && lsb[0]);
  endfunction

endpackage

// File: rtl/dmem_bus_ctrl_if.sv
// Core-side request/response handshake between the MEM stage (master) and
// the data-memory bus controller (slave).
interface dmem_bus_ctrl_if #(
  parameter int BIT_WIDTH = 32
);
  logic                     req_valid;
  logic                     req_ready;
  logic                     req_write;
  mem_bus_pkg::size_t       req_size;
  logic                     req_signed;
  logic [BIT_WIDTH-1:0]     req_addr;
  logic [BIT_WIDTH-1:0]     req_wdata;
  logic                     resp_valid;
  logic [BIT_WIDTH-1:0]     resp_rdata;
  logic                     resp_err;

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_bus_ctrl_ld_ext.sv
// Load-data extension: memory returns halves/bytes right-aligned; widen them
// to a full word with sign or zero fill.
module ld_ext
  import mem_bus_pkg::*;
#(
  parameter int BIT_WIDTH = 32
) (
  input  size_t                size_i,
  input  logic                 signed_i,
  input  logic [BIT_WIDTH-1:0] raw_i,
  output logic [BIT_WIDTH-1:0] ext_o
);

  always_comb begin
    ext_o = raw_i;
    case (norm_size(size_i))
      SZ_WORD: ext_o = raw_i;
      SZ_HALF: ext_o = {{(BIT_WIDTH-16){signed_i & raw_i[15]}}, raw_i[15:0]};
      default: ext_o = {{(BIT_WIDTH-8){signed_i & raw_i[7]}}, raw_i[7:0]};
    endcase
  end

endmodule

// File: rtl/dmem_bus_ctrl.sv
// Data-memory bus controller: one load/store per transaction, waits for the
// active-low acknowledge, extends load data, and aborts on a watchdog timeout.
module dmem_bus_ctrl
  import mem_bus_pkg::*;
#(
  parameter int BIT_WIDTH = 32,
  parameter int TIMEOUT   = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  dmem_bus_ctrl_if.slave       core,
  output logic [BIT_WIDTH-1:0] DAD,
  output logic                 MREQ,
  output logic                 WRITE,
  output size_t                SIZE,
  inout  wire  [BIT_WIDTH-1:0] DDT,
  input  logic                 ACKD_n
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_e               state_q, state_d;
  logic [BIT_WIDTH-1:0] addr_q, wdata_q, wdata_d;
  logic                 write_q, signed_q;
  size_t                size_q;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 resp_valid_q, resp_valid_d;
  logic                 resp_err_q, resp_err_d;
  logic [BIT_WIDTH-1:0] resp_rdata_q, resp_rdata_d;
  logic [BIT_WIDTH-1:0] ld_data;
  logic                 mis, start, ack, tmo;

  assign mis   = misaligned(core.req_size, core.req_addr[1:0]);
  assign start = (state_q == ST_IDLE) && core.req_valid && !mis;
  assign ack   = !ACKD_n;
  assign tmo   = (cnt_q == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start)      state_d = ST_BUS;
      ST_BUS:  if (ack || tmo) state_d = ST_IDLE;
      default:                 state_d = ST_IDLE;
    endcase
  end

  // Ack has priority over the watchdog when both land on the same edge.
  always_comb begin
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = '0;
    cnt_d        = cnt_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (core.req_valid && mis) begin
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
        end
      end
      ST_BUS: begin
        cnt_d = cnt_q + CW'(1);
        if (ack) begin
          resp_valid_d = 1'b1;
          resp_rdata_d = write_q ? '0 : ld_data;
        end else if (tmo) begin
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    case (norm_size(core.req_size))
      SZ_WORD: wdata_d = core.req_wdata;
      SZ_HALF: wdata_d = {{(BIT_WIDTH-16){1'b0}}, core.req_wdata[15:0]};
      default: wdata_d = {{(BIT_WIDTH-8){1'b0}}, core.req_wdata[7:0]};
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q       <= '0;
      wdata_q      <= '0;
      write_q      <= 1'b0;
      signed_q     <= 1'b0;
      size_q       <= SZ_WORD;
      cnt_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      if (start) begin
        addr_q   <= core.req_addr;
        wdata_q  <= wdata_d;
        write_q  <= core.req_write;
        signed_q <= core.req_signed;
        size_q   <= norm_size(core.req_size);
      end
      cnt_q        <= cnt_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  ld_ext #(.BIT_WIDTH(BIT_WIDTH)) u_ld_ext (
    .size_i   (size_q),
    .signed_i (signed_q),
    .raw_i    (DDT),
    .ext_o    (ld_data)
  );

  assign core.req_ready  = (state_q == ST_IDLE);
  assign core.resp_valid = resp_valid_q;
  assign core.resp_err   = resp_err_q;
  assign core.resp_rdata = resp_rdata_q;

  assign MREQ  = (state_q == ST_BUS);
  assign DAD   = addr_q;
  assign WRITE = write_q;
  assign SIZE  = size_q;
  assign DDT   = (MREQ && write_q) ? wdata_q : {BIT_WIDTH{1'bz}};

endmodule

// File: tb/tb_dmem_bus_ctrl.sv
// Scoreboard bench for dmem_bus_ctrl: a simple memory model answers bus
// requests, expected responses are queued at issue and popped on resp_valid.
module tb_dmem_bus_ctrl;
  import mem_bus_pkg::*;

  localparam int W   = 32;
  localparam int TMO = 4;

  typedef struct {
    string       tag;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  DAD;
  logic          MREQ, WRITE, ACKD_n;
  size_t         SIZE;
  wire  [W-1:0]  DDT;
  logic          mem_oe, tb_oe;
  logic [W-1:0]  mem_val, tb_val;

  dmem_bus_ctrl_if #(.BIT_WIDTH(W)) bus_if ();

  assign DDT = mem_oe ? mem_val : (tb_oe ? tb_val : {W{1'bz}});

  dmem_bus_ctrl #(.BIT_WIDTH(W), .TIMEOUT(TMO)) dut (
    .clk    (clk),
    .rst    (rst),
    .core   (bus_if),
    .DAD    (DAD),
    .MREQ   (MREQ),
    .WRITE  (WRITE),
    .SIZE   (SIZE),
    .DDT    (DDT),
    .ACKD_n (ACKD_n)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_err = 0;
  exp_t        exp_q[$];
  int          resp_cnt = 0;
  int          mreq_cnt = 0;
  int          mem_lat = 0;
  logic [W-1:0] mem_rdata = '0;
  logic [W-1:0] exp_dad = '0;
  logic [W-1:0] exp_ddt = '0;
  logic         exp_wr = 1'b0;
  size_t        exp_sz = SZ_WORD;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Memory model + response monitor, sampled on the falling edge.
  initial begin
    int   bus_cyc;
    exp_t e;
    bus_cyc = 0;
    ACKD_n  = 1'b1;
    mem_oe  = 1'b0;
    mem_val = '0;
    forever begin
      @(negedge clk);
      if (bus_if.resp_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_resp", 32'(bus_if.resp_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk({e.tag, "_rdata"}, bus_if.resp_rdata, e.rdata);
          chk({e.tag, "_err"}, 32'(bus_if.resp_err), 32'(e.err));
        end
        resp_cnt++;
      end
      if (!ACKD_n) bus_cyc = 0;
      ACKD_n = 1'b1;
      mem_oe = 1'b0;
      if (MREQ) begin
        mreq_cnt++;
        bus_cyc++;
        chk("bus_dad", DAD, exp_dad);
        chk("bus_write", 32'(WRITE), 32'(exp_wr));
        chk("bus_size", 32'(SIZE), 32'(exp_sz));
        if (WRITE) chk("bus_ddt", DDT, exp_ddt);
        if (bus_cyc == mem_lat) begin
          ACKD_n = 1'b0;
          if (!WRITE) begin
            mem_val = mem_rdata;
            mem_oe  = 1'b1;
          end
        end
      end else begin
        bus_cyc = 0;
      end
    end
  end

  // Drive a pattern onto DDT briefly; it only reads back intact if the DUT has released the bus.
  task automatic probe(input string tag);
    tb_val = 32'h5A5A_C3C3;
    tb_oe  = 1'b1;
    #1;
    chk(tag, DDT, 32'h5A5A_C3C3);
    tb_oe  = 1'b0;
  endtask

  task automatic issue(input logic wr, input size_t sz, input logic sg,
                       input logic [W-1:0] addr, input logic [W-1:0] wd,
                       input int lat, input logic [W-1:0] mdata, input logic [W-1:0] ddt_e);
    mem_lat   = lat;
    mem_rdata = mdata;
    exp_dad   = addr;
    exp_wr    = wr;
    exp_sz    = sz;
    exp_ddt   = ddt_e;
    chk("req_ready", 32'(bus_if.req_ready), 32'd1);
    bus_if.req_valid  = 1'b1;
    bus_if.req_write  = wr;
    bus_if.req_size   = sz;
    bus_if.req_signed = sg;
    bus_if.req_addr   = addr;
    bus_if.req_wdata  = wd;
    @(posedge clk);
    #1;
    bus_if.req_valid  = 1'b0;
  endtask

  task automatic txn(input string tag, input logic wr, input size_t sz, input logic sg,
                     input logic [W-1:0] addr, input logic [W-1:0] wd, input int lat,
                     input logic [W-1:0] mdata, input logic [W-1:0] ddt_e,
                     input logic [W-1:0] exp_rd, input logic exp_err,
                     input int exp_mreq, input int exp_cyc);
    exp_t e;
    int   start, m0, cyc, got;
    e.tag = tag; e.rdata = exp_rd; e.err = exp_err;
    exp_q.push_back(e);
    start = resp_cnt;
    m0    = mreq_cnt;
    cyc   = 0;
    got   = 0;
    issue(wr, sz, sg, addr, wd, lat, mdata, ddt_e);
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      #1;
      if (resp_cnt != start) begin
        cyc = i;
        got = 1;
        break;
      end
    end
    chk({tag, "_done"}, got, 1);
    chk({tag, "_lat"}, cyc, exp_cyc);
    chk({tag, "_mreq"}, mreq_cnt - m0, exp_mreq);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, errors=%0d", n_err);
    $fatal(1);
  end

  initial begin
    int r0;
    rst   = 1'b0;
    tb_oe = 1'b0;
    tb_val = '0;
    bus_if.req_valid  = 1'b0;
    bus_if.req_write  = 1'b0;
    bus_if.req_size   = SZ_WORD;
    bus_if.req_signed = 1'b0;
    bus_if.req_addr   = '0;
    bus_if.req_wdata  = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ready", 32'(bus_if.req_ready), 32'd1);
    chk("rst_resp_valid", 32'(bus_if.resp_valid), 32'd0);
    chk("rst_resp_err", 32'(bus_if.resp_err), 32'd0);
    chk("rst_resp_rdata", bus_if.resp_rdata, 32'd0);
    chk("rst_mreq", 32'(MREQ), 32'd0);
    chk("rst_write", 32'(WRITE), 32'd0);
    chk("rst_size", 32'(SIZE), 32'd0);
    chk("rst_dad", DAD, 32'd0);
    probe("rst_ddt_z");
    @(negedge clk);
    rst = 1'b1;
    #1;

    //  tag      wr  size     sg  addr           wdata          lat mdata          ddt            exp_rd         err mreq cyc
    txn("wld",   0, SZ_WORD, 0, 32'h0800_0010, 32'h0,         1, 32'h1234_5678, 32'h0,         32'h1234_5678, 0, 1, 2);
    txn("sbld",  0, SZ_BYTE, 1, 32'h0800_0013, 32'h0,         1, 32'h0000_0080, 32'h0,         32'hFFFF_FF80, 0, 1, 2);
    txn("ubld",  0, SZ_BYTE, 0, 32'h0800_0011, 32'h0,         1, 32'h0000_0080, 32'h0,         32'h0000_0080, 0, 1, 2);
    txn("shld",  0, SZ_HALF, 1, 32'h0800_0002, 32'h0,         1, 32'h0000_8001, 32'h0,         32'hFFFF_8001, 0, 1, 2);
    txn("uhld",  0, SZ_HALF, 0, 32'h0800_0006, 32'h0,         1, 32'h0000_8001, 32'h0,         32'h0000_8001, 0, 1, 2);
    txn("swld",  0, SZ_WORD, 1, 32'h0800_0020, 32'h0,         2, 32'h8000_0000, 32'h0,         32'h8000_0000, 0, 2, 3);
    txn("bst",   1, SZ_BYTE, 0, 32'hF000_0000, 32'h1234_56AB, 3, 32'h0,         32'h0000_00AB, 32'h0,         0, 3, 4);
    probe("bst_ddt_z");
    txn("hst",   1, SZ_HALF, 0, 32'hF000_0002, 32'hCAFE_BEEF, 1, 32'h0,         32'h0000_BEEF, 32'h0,         0, 1, 2);
    txn("wst",   1, SZ_WORD, 0, 32'h2000_0004, 32'hDEAD_BEEF, 2, 32'h0,         32'hDEAD_BEEF, 32'h0,         0, 2, 3);
    probe("wst_ddt_z");
    txn("mis_w", 0, SZ_WORD, 0, 32'h0800_0002, 32'h0,         1, 32'h0000_0055, 32'h0,         32'h0,         1, 0, 1);
    txn("mis_h", 1, SZ_HALF, 0, 32'h0800_0003, 32'h0000_1234, 1, 32'h0,         32'h0000_1234, 32'h0,         1, 0, 1);
    txn("tmo",   0, SZ_WORD, 0, 32'h3000_0000, 32'h0,         0, 32'h0,         32'h0,         32'h0,         1, 4, 5);
    txn("ack4",  0, SZ_WORD, 0, 32'h3000_0008, 32'h0,         4, 32'hA5A5_0F0F, 32'h0,         32'hA5A5_0F0F, 0, 4, 5);
    txn("tmo_st",1, SZ_WORD, 0, 32'h3000_000C, 32'h0000_0077, 0, 32'h0,         32'h0000_0077, 32'h0,         1, 4, 5);
    probe("tmo_st_ddt_z");

    // Reset in the middle of a store that memory never acknowledges.
    r0 = resp_cnt;
    issue(1, SZ_WORD, 0, 32'h1000_0000, 32'h1122_3344, 0, 32'h0, 32'h1122_3344);
    @(negedge clk);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("midrst_mreq", 32'(MREQ), 32'd0);
    probe("midrst_ddt_z");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("midrst_no_resp", resp_cnt - r0, 0);

    txn("post_rst", 0, SZ_WORD, 0, 32'h0800_0040, 32'h0,    1, 32'h0BAD_F00D, 32'h0,         32'h0BAD_F00D, 0, 1, 2);

    repeat (3) @(negedge clk);
    chk("sb_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/dmem_bus_ctrl.md
# dmem_bus_ctrl

Data-memory bus controller between the pipeline's MEM stage and the external data port of `top` (`DAD`/`MREQ`/`WRITE`/`SIZE`/`DDT`/`ACKD_n`). It accepts one load or store per transaction from the core and drives the bus. It waits for the active-low acknowledge, sign- or zero-extends load data and returns a single-cycle response. A watchdog aborts transactions the memory never acknowledges.

## Interface
- `BIT_WIDTH`, 32, data/address width.
- `TIMEOUT`, 255, cycles in BUS without acknowledge before abort (≥1).
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `req_valid` in 1: MEM stage presents a request.
- `req_ready` out 1: controller can accept (high only in IDLE).
- `req_write` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 word, 01 half, 10 byte (11 treated as byte).
- `req_signed` in 1: loads only; 1 = sign-extend.
- `req_addr` in BIT_WIDTH: byte address.
- `req_wdata` in BIT_WIDTH: store data, right-aligned.
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_rdata` out BIT_WIDTH: extended load data; 0 for stores and errors.
- `resp_err` out 1: valid with `resp_valid`; misaligned or timeout.
- `DAD` out BIT_WIDTH: bus address.
- `MREQ` out 1: bus request.
- `WRITE` out 1: bus direction.
- `SIZE` out 2: bus size, same encoding as `req_size`.
- `DDT` inout BIT_WIDTH: bus data; driven only while `MREQ && WRITE`, else high-Z.
- `ACKD_n` in 1: memory acknowledge, active-low.

## Operation
- FSM states: IDLE, BUS.
- IDLE: `req_ready`=1. On `req_valid`, latch the request.
  - Aligned request: go to BUS.
  - Misaligned request (word with `addr[1:0]`≠0, or half with `addr[0]`≠0): stay in IDLE. Pulse `resp_valid` with `resp_err`=1 next cycle. `MREQ` is never raised.
- BUS: `MREQ`=1; `DAD`, `WRITE`, `SIZE` hold latched values. `DDT` = latched wdata when writing.
  - Half stores place data in `DDT[15:0]`; byte stores place data in `DDT[7:0]`; upper bits 0.
- Acknowledge: `ACKD_n` sampled only in BUS, at each rising edge. Sampled 0 → capture `DDT` (loads), go to IDLE, pulse `resp_valid` with `resp_err`=0.
- Load extension: memory returns half/byte right-aligned and zero-padded.
  - Half: `req_signed` replicates bit 15, otherwise zero-extend.
  - Byte: `req_signed` replicates bit 7, otherwise zero-extend.
  - Word: passes through unchanged.
- Watchdog: counter cleared on entering BUS, incremented each BUS cycle. Reaching `TIMEOUT` without ack → IDLE, `resp_valid`=1, `resp_err`=1, `resp_rdata`=0.
- Ack and timeout on the same edge: ack wins, no error.
- Addresses are passed through unmodified; stdout/exit addresses need no special handling here.

## Timing
- Reset values: `req_ready`=1, `resp_valid`=0, `resp_err`=0, `resp_rdata`=0, `MREQ`=0, `WRITE`=0, `SIZE`=00, `DAD`=0, `DDT` high-Z, state IDLE, counter 0.
- All outputs are registered.
- Accept at edge k → `MREQ` high from k. Earliest ack sample is edge k+1 → `resp_valid` high during cycle k+1, `MREQ` low from k+1.
- Zero-wait memory: 2 cycles from accept to response. A new request can be accepted while `resp_valid` is high. Peak throughput is 1 request per 2 cycles.
- Latency: N wait cycles add N cycles.
- Misaligned request: response the cycle after acceptance.
- Reset asserted mid-transaction: `MREQ` drops and `DDT` releases immediately (asynchronous). No response is generated and the in-flight request is lost.

## Structure
- Package `mem_bus_pkg`:
  - SIZE encodings `SZ_WORD`=2'b00, `SZ_HALF`=2'b01, `SZ_BYTE`=2'b10.
  - FSM state enum.
  - Shared by the MEM stage and the future instruction-fetch controller.
- Sub-module `ld_ext` (combinational): size + signed + raw bus data → extended word. Reused by the writeback path.
- Top of block: FSM, request latch, watchdog counter, tri-state driver.

## Test plan
- Word load, addr 0x0800_0010, memory returns 0x1234_5678 after 1 cycle → `MREQ` high 1 cycle, `SIZE`=00, `resp_rdata`=0x1234_5678, `resp_err`=0, 2 cycles total.
- Signed byte load, memory returns 0x0000_0080 → `resp_rdata`=0xFFFF_FF80. Unsigned byte load, same return → 0x0000_0080. Signed half load, return 0x0000_8001 → 0xFFFF_8001.
- Byte store 0xAB to 0xF000_0000 with 3-cycle ack latency → `DDT`=0x0000_00AB and `WRITE`=1 held 3 cycles, then `resp_valid`, `DDT` high-Z afterwards.
- Misaligned word load at 0x0800_0002 → no `MREQ`, `resp_valid`=1 and `resp_err`=1 one cycle after accept.
- `TIMEOUT`=4, `ACKD_n` held 1 → `MREQ` high 4 cycles, then `resp_err`=1, `resp_rdata`=0. Ack arriving on the 4th edge instead → `resp_err`=0.
- `rst` pulled low during BUS → `MREQ`=0 and `DDT` high-Z within the same cycle, no `resp_valid`. After release, the next request completes normally.
